// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle signed WIDTH x WIDTH multiply and WIDTH / WIDTH divide engine.
//   The control unit pulses start with op/A/B, stalls on busy, and takes the
//   2*WIDTH-bit C word when done pulses. C then holds until the next
//   operation completes.
//
//   MUL: Booth recoding over {acc, Q, q-1} with an arithmetic right shift per
//        iteration; exact 2*WIDTH-bit signed product.
//   DIV: restoring division on operand magnitudes, followed by sign fix-up.
//        Quotient truncates toward zero, remainder takes the dividend's sign.
//        Divide by zero gives quotient = all ones, remainder = A, div_zero = 1.
//
//   Optional build macro:
//     BOOTH_RADIX4_EN  defined   -> MUL uses radix-4 bit-pair recoding,
//                                   WIDTH/2 iterations (WIDTH must be even).
//                      undefined -> MUL uses radix-2 Booth, WIDTH iterations.
//     DIV and all other port timing are the same in both builds.
//
//   Timing: start sampled at edge 0 -> one set-up edge (magnitudes, Booth
//   operands), N iteration edges, one fix-up edge that writes C; done is high
//   after edge N+2.
//
// Ports
//   Clock     in   1        rising-edge clock
//   Clear     in   1        synchronous active-high reset, beats everything
//   start     in   1        begin operation, only honoured while idle
//   op        in   1        0 = MUL, 1 = DIV (latched with start)
//   A         in   WIDTH    multiplicand / dividend, two's complement
//   B         in   WIDTH    multiplier / divisor, two's complement
//   C         out  2*WIDTH  MUL: product. DIV: {remainder, quotient}
//   busy      out  1        high from the accepted start edge through DONE
//   done      out  1        one-cycle pulse, C valid from this cycle on
//   div_zero  out  1        DIV with B == 0; held until the next start
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  // Accumulator carries two guard bits: enough for acc +/- 2M in radix-4 and
  // for |B| = 2^(WIDTH-1) in the divider's trial subtraction.
  localparam int AW    = WIDTH + 2;
  localparam int DIV_N = WIDTH;
`ifdef BOOTH_RADIX4_EN
  localparam int MUL_N = WIDTH / 2;
`else
  localparam int MUL_N = WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               prep_q, prep_d;     // first RUN edge is operand set-up
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [AW-1:0]      acc_q, acc_d;       // MUL accumulator / DIV remainder
  logic [WIDTH-1:0]   q_q, q_d;           // MUL multiplier / DIV quotient
  logic               qm1_q, qm1_d;       // Booth q-1 bit
  logic [AW-1:0]      m_q, m_d;           // MUL sext(B) / DIV |B|
  logic [2*WIDTH-1:0] c_q, c_d;
  logic               dz_q, dz_d;

  // ---------------------------------------------------------------------------
  // Booth step
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    mul_sum;
  logic [AW-1:0]    mul_acc_n;
  logic [WIDTH-1:0] mul_q_n;
  logic             mul_qm1_n;

`ifdef BOOTH_RADIX4_EN
  logic [AW-1:0] m2;

  always_comb begin
    m2 = {m_q[AW-2:0], 1'b0};
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: mul_sum = acc_q + m_q;
      3'b011:         mul_sum = acc_q + m2;
      3'b100:         mul_sum = acc_q - m2;
      3'b101, 3'b110: mul_sum = acc_q - m_q;
      default:        mul_sum = acc_q;
    endcase
    // {sum, Q, q-1} >>> 2: the new q-1 is the old Q[1]
    {mul_acc_n, mul_q_n, mul_qm1_n} = {{2{mul_sum[AW-1]}}, mul_sum, q_q[WIDTH-1:1]};
  end
`else
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   mul_sum = acc_q + m_q;
      2'b10:   mul_sum = acc_q - m_q;
      default: mul_sum = acc_q;
    endcase
    // {sum, Q, q-1} >>> 1: the new q-1 is the old Q[0]
    {mul_acc_n, mul_q_n, mul_qm1_n} = {mul_sum[AW-1], mul_sum, q_q};
  end
`endif

  // ---------------------------------------------------------------------------
  // Restoring divide step: shift {rem, quotient} left, trial-subtract |B|.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   div_shift;
  logic [AW-1:0]    div_trial;
  logic [AW-1:0]    div_acc_n;
  logic [WIDTH-1:0] div_q_n;

  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {1'b0, m_q[WIDTH:0]};
    if (div_trial[AW-1]) begin
      div_acc_n = {1'b0, div_shift};        // negative: restore
    end else begin
      div_acc_n = div_trial;
    end
    div_q_n = {q_q[WIDTH-2:0], ~div_trial[AW-1]};
  end

  // ---------------------------------------------------------------------------
  // Operand magnitudes in WIDTH+1 bits so that the most negative value has a
  // representable magnitude.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] a_ext, b_ext, a_mag, b_mag;

  always_comb begin
    a_ext = {a_q[WIDTH-1], a_q};
    b_ext = {b_q[WIDTH-1], b_q};
    a_mag = a_ext[WIDTH] ? (~a_ext + 1'b1) : a_ext;
    b_mag = b_ext[WIDTH] ? (~b_ext + 1'b1) : b_ext;
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up of the divider result
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    quot_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~q_q + 1'b1) : q_q;
    rem_fix  = a_q[WIDTH-1] ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prep_d  = prep_q;
    iter_d  = iter_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    c_d     = c_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = A;
          b_d     = B;
          prep_d  = 1'b1;
          iter_d  = op ? CNT_W'(DIV_N) : CNT_W'(MUL_N);
          dz_d    = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (prep_q) begin
          // Set-up edge: load the shift registers, no iteration counted.
          prep_d = 1'b0;
          qm1_d  = 1'b0;
          if (op_q) begin
            // Dividend magnitude sits in {acc, Q}; its top bit is always 0
            // after the magnitude step but is carried for completeness.
            acc_d = AW'(a_mag[WIDTH]);
            q_d   = a_mag[WIDTH-1:0];
            m_d   = {1'b0, b_mag};
          end else begin
            acc_d = '0;
            q_d   = a_q;
            m_d   = {{2{b_q[WIDTH-1]}}, b_q};
          end
        end else begin
          if (op_q) begin
            acc_d = div_acc_n;
            q_d   = div_q_n;
          end else begin
            acc_d = mul_acc_n;
            q_d   = mul_q_n;
            qm1_d = mul_qm1_n;
          end
          iter_d = iter_q - 1'b1;
          if (iter_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (!op_q) begin
          c_d = {acc_q[WIDTH-1:0], q_q};
        end else if (b_q == '0) begin
          c_d  = {a_q, {WIDTH{1'b1}}};
          dz_d = 1'b1;
        end else begin
          c_d = {rem_fix, quot_fix};
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prep_q  <= 1'b0;
      iter_q  <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      c_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prep_q  <= prep_d;
      iter_q  <= iter_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
    end
  end

  assign C        = c_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed, table-driven bench for mul_div_unit (WIDTH = 32), plus hand
//   sequences for start-while-busy and Clear in mid-operation.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int MUL_LAT = 18;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int NV      = 11;

  logic          Clock = 1'b0;
  logic          Clear;
  logic          start;
  logic          op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [2*W-1:0] C;
  logic          busy;
  logic          done;
  logic          div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Clear    (Clear),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .C        (C),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  typedef struct {
    logic           op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] c;
    logic           dz;
    int             lat;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done. lat = -1 on timeout.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_drops, output logic dz_at_start);
    @(negedge Clock);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge Clock); #1;             // edge 0
    lat = -1;
    busy_drops = busy ? 0 : 1;
    dz_at_start = div_zero;
    @(negedge Clock);
    start = 1'b0; op = ~o; A = $urandom; B = $urandom;
    for (int e = 1; e <= 100; e++) begin
      @(posedge Clock); #1;
      if (!busy) busy_drops++;
      if (done) begin
        lat = e;
        break;
      end
    end
  endtask

  initial begin
    int lat, drops, seen;
    logic dz0;
    logic [63:0] c_prev;

    vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, MUL_LAT};
    vecs[1]  = '{1'b0, 32'h80000000,  32'h80000000, 64'h40000000_00000000, 1'b0, MUL_LAT};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'h00000000_00000001, 1'b0, MUL_LAT};
    vecs[3]  = '{1'b0, 32'd12345,     32'd6789,     64'h00000000_04FED79D, 1'b0, MUL_LAT};
    vecs[4]  = '{1'b0, 32'h7FFFFFFF,  32'h80000000, 64'hC0000000_80000000, 1'b0, MUL_LAT};
    vecs[5]  = '{1'b1, 32'hFFFFFFEF,  32'd5,        64'hFFFFFFFE_FFFFFFFD, 1'b0, DIV_LAT};
    vecs[6]  = '{1'b1, 32'd17,        32'hFFFFFFFB, 64'h00000002_FFFFFFFD, 1'b0, DIV_LAT};
    vecs[7]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, DIV_LAT};
    vecs[8]  = '{1'b1, 32'd100,       32'd0,        64'h00000064_FFFFFFFF, 1'b1, DIV_LAT};
    vecs[9]  = '{1'b1, 32'd100,       32'd7,        64'h00000002_0000000E, 1'b0, DIV_LAT};
    vecs[10] = '{1'b1, 32'hFFFFFF9C,  32'd0,        64'hFFFFFF9C_FFFFFFFF, 1'b1, DIV_LAT};

    // Reset
    Clear = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
    @(posedge Clock); @(posedge Clock); #1;
    check("reset_C", C, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    @(negedge Clock);
    Clear = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, drops, dz0);
      $display("vec %0d op=%0d a=%h b=%h -> C=%h div_zero=%0b latency=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, C, div_zero, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_held", i), 64'(drops), 64'd0);
      check($sformatf("v%0d_dz_cleared_at_start", i), {63'd0, dz0}, 64'd0);
      check($sformatf("v%0d_C", i), C, vecs[i].c);
      check($sformatf("v%0d_div_zero", i), {63'd0, div_zero}, {63'd0, vecs[i].dz});
      @(posedge Clock); #1;
      check($sformatf("v%0d_done_one_cycle", i), {62'd0, done, busy}, 64'd0);
      check($sformatf("v%0d_C_held", i), C, vecs[i].c);
      check($sformatf("v%0d_div_zero_held", i), {63'd0, div_zero}, {63'd0, vecs[i].dz});
    end

    // start pulsed again at edge 5 of a MUL: ignored
    c_prev = C;
    @(negedge Clock);
    start = 1'b1; op = 1'b0; A = 32'd7; B = 32'hFFFFFFFD;
    @(posedge Clock); #1;
    check("busy_start_C_not_cleared", C, c_prev);
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(negedge Clock);
      start = (e == 5);
      if (e == 5) begin
        op = 1'b1; A = 32'd100; B = 32'd100;
      end
      @(posedge Clock); #1;
      if (done) begin
        lat = e;
        break;
      end
    end
    start = 1'b0;
    $display("restart-while-busy: C=%h latency=%0d", C, lat);
    check("busy_start_latency", 64'(lat), 64'(MUL_LAT));
    check("busy_start_C", C, 64'hFFFFFFFF_FFFFFFEB);
    @(posedge Clock); #1;
    check("busy_start_no_second_op", {62'd0, done, busy}, 64'd0);

    // Clear sampled at edge 10 of a DIV: abort, no done ever
    @(negedge Clock);
    start = 1'b1; op = 1'b1; A = 32'd1000; B = 32'd3;
    @(posedge Clock);
    for (int e = 1; e <= 10; e++) begin
      @(negedge Clock);
      start = 1'b0;
      Clear = (e == 10);
      @(posedge Clock);
    end
    #1;
    check("clear_mid_busy", {63'd0, busy}, 64'd0);
    check("clear_mid_done", {63'd0, done}, 64'd0);
    check("clear_mid_C", C, 64'd0);
    @(negedge Clock);
    Clear = 1'b0;
    seen = 0;
    for (int e = 0; e < 60; e++) begin
      @(posedge Clock); #1;
      if (done || busy) seen++;
    end
    $display("clear-mid-op: C=%h busy/done cycles after abort=%0d", C, seen);
    check("clear_mid_no_done", 64'(seen), 64'd0);

    // Engine usable after abort
    run_op(1'b1, 32'd1000, 32'd3, lat, drops, dz0);
    $display("post-clear DIV 1000/3 -> C=%h latency=%0d", C, lat);
    check("post_clear_latency", 64'(lat), 64'(DIV_LAT));
    check("post_clear_C", C, 64'h00000001_0000014D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
